// File: rtl/fixed_mac_arb_pkg.sv
// Shared types, default widths and the round-robin pick helper for fixed_mac_arbiter.
package fixed_mac_arb_pkg;

  localparam int NREQ_DEF    = 4;
  localparam int WA_DEF      = 16;
  localparam int WB_DEF      = 12;
  localparam int WO_DEF      = 20;
  localparam int TIMEOUT_DEF = 64;
  localparam int LENW_DEF    = 8;
  localparam int MAX_REQ     = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    STREAM   = 2'd1,
    WAIT_RES = 2'd2,
    DELIVER  = 2'd3
  } arb_state_t;

  // First requester at or after ptr, wrapping modulo nreq; returns ptr when nothing requests.
  function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                         input logic [2:0] ptr,
                                         input int nreq);
    logic [2:0] pick;
    logic       found;
    int         idx;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = (int'(ptr) + k) % nreq;
      if (k < nreq && !found && req[3'(idx)]) begin
        pick  = 3'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/fixed_mac_arbiter_rr_arbiter.sv
// Combinational round-robin pick; the pointer moves past the last served requester.
module rr_arbiter
  import fixed_mac_arb_pkg::*;
#(
  parameter  int NREQ = NREQ_DEF,
  localparam int GW   = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  input  logic [GW-1:0]   last_grant,
  output logic [GW-1:0]   pick,
  output logic            any_req
);

  logic [GW-1:0]      ptr;
  logic [MAX_REQ-1:0] req_ext;
  logic [2:0]         pick_ext;

  always_comb begin
    req_ext            = '0;
    req_ext[NREQ-1:0]  = req;
  end

  assign pick_ext = rr_pick(req_ext, 3'(ptr), NREQ);
  assign pick     = GW'(pick_ext);
  assign any_req  = |req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (last_grant == GW'(NREQ - 1)) ? '0 : last_grant + 1'b1;
    end
  end

endmodule

// File: rtl/fixed_mac_arbiter.sv
// Shares one fixed_mac between NREQ requesters: one job (A+B streams) per grant,
// result returned with requester id, beat count and status flags.
module fixed_mac_arbiter
  import fixed_mac_arb_pkg::*;
#(
  parameter  int NREQ    = NREQ_DEF,
  parameter  int WA      = WA_DEF,
  parameter  int WB      = WB_DEF,
  parameter  int WO      = WO_DEF,
  parameter  int TIMEOUT = TIMEOUT_DEF,
  parameter  int LENW    = LENW_DEF,
  localparam int GW      = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ*WA-1:0] s_a_data,
  input  logic [NREQ-1:0]    s_a_valid,
  input  logic [NREQ-1:0]    s_a_last,
  output logic [NREQ-1:0]    s_a_ready,
  input  logic [NREQ*WB-1:0] s_b_data,
  input  logic [NREQ-1:0]    s_b_valid,
  input  logic [NREQ-1:0]    s_b_last,
  output logic [NREQ-1:0]    s_b_ready,
  input  logic [NREQ-1:0]    s_of_sat,
  input  logic [NREQ-1:0]    s_uf_sat,
  output logic [WA-1:0]      m_a_data,
  output logic               m_a_valid,
  output logic               m_a_last,
  input  logic               m_a_ready,
  output logic [WB-1:0]      m_b_data,
  output logic               m_b_valid,
  output logic               m_b_last,
  input  logic               m_b_ready,
  output logic               m_of_sat,
  output logic               m_uf_sat,
  input  logic [WO-1:0]      m_out_data,
  input  logic               m_out_valid,
  output logic               m_out_ready,
  input  logic               m_overflow,
  input  logic               m_underflow,
  output logic [WO-1:0]      res_data,
  output logic [GW-1:0]      res_id,
  output logic [LENW-1:0]    res_len,
  output logic               res_overflow,
  output logic               res_underflow,
  output logic               res_timeout,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               busy,
  output arb_state_t         fsm_state
);

  localparam int TW = $clog2(TIMEOUT + 1);

  // Valid/ready: a beat or result transfers on a rising edge where both are high;
  // the source holds its payload stable while valid is high and ready is low.

  logic rst_meta, rst_n;

  // Reset asserts asynchronously; release is re-timed to clk.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) {rst_meta, rst_n} <= 2'b00;
    else        {rst_meta, rst_n} <= {1'b1, rst_meta};
  end

  arb_state_t      state, state_nxt;
  logic [GW-1:0]   grant, pick;
  logic            any_req, take_grant, arb_advance;
  logic            a_done, b_done, a_done_nxt, b_done_nxt, a_hs, b_hs;
  logic [LENW-1:0] beat_cnt;
  logic [TW-1:0]   tmo_cnt;
  logic            tmo_hit;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (s_a_valid | s_b_valid),
    .advance    (arb_advance),
    .last_grant (grant),
    .pick       (pick),
    .any_req    (any_req)
  );

  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    m_a_data    = '0;
    m_a_valid   = 1'b0;
    m_a_last    = 1'b0;
    s_a_ready   = '0;
    m_b_data    = '0;
    m_b_valid   = 1'b0;
    m_b_last    = 1'b0;
    s_b_ready   = '0;
    m_out_ready = 1'b0;
    res_valid   = 1'b0;
    take_grant  = 1'b0;
    arb_advance = 1'b0;
    a_hs        = 1'b0;
    b_hs        = 1'b0;
    a_done_nxt  = a_done;
    b_done_nxt  = b_done;
    case (state)
      IDLE: begin
        if (any_req) begin
          take_grant = 1'b1;
          state_nxt  = STREAM;
        end
      end
      STREAM: begin
        m_a_data         = s_a_data[grant*WA +: WA];
        m_a_valid        = s_a_valid[grant] & !a_done;
        m_a_last         = s_a_last[grant] & !a_done;
        s_a_ready[grant] = m_a_ready & !a_done;
        m_b_data         = s_b_data[grant*WB +: WB];
        m_b_valid        = s_b_valid[grant] & !b_done;
        m_b_last         = s_b_last[grant] & !b_done;
        s_b_ready[grant] = m_b_ready & !b_done;
        a_hs             = m_a_valid & m_a_ready;
        b_hs             = m_b_valid & m_b_ready;
        a_done_nxt       = a_done | (a_hs & m_a_last);
        b_done_nxt       = b_done | (b_hs & m_b_last);
        if (a_done_nxt && b_done_nxt) state_nxt = WAIT_RES;
      end
      WAIT_RES: begin
        m_out_ready = 1'b1;
        if (m_out_valid || tmo_hit) state_nxt = DELIVER;
      end
      DELIVER: begin
        res_valid = 1'b1;
        if (res_ready) begin
          arb_advance = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant         <= '0;
      a_done        <= 1'b0;
      b_done        <= 1'b0;
      beat_cnt      <= '0;
      tmo_cnt       <= '0;
      m_of_sat      <= 1'b0;
      m_uf_sat      <= 1'b0;
      res_data      <= '0;
      res_overflow  <= 1'b0;
      res_underflow <= 1'b0;
      res_timeout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (take_grant) begin
            grant    <= pick;
            m_of_sat <= s_of_sat[pick];
            m_uf_sat <= s_uf_sat[pick];
            a_done   <= 1'b0;
            b_done   <= 1'b0;
            beat_cnt <= '0;
          end
        end
        STREAM: begin
          a_done <= a_done_nxt;
          b_done <= b_done_nxt;
          if (a_hs && beat_cnt != '1) beat_cnt <= beat_cnt + 1'b1;
          if (a_done_nxt && b_done_nxt) tmo_cnt <= '0;
        end
        WAIT_RES: begin
          if (m_out_valid) begin
            res_data      <= m_out_data;
            res_overflow  <= m_overflow;
            res_underflow <= m_underflow;
            res_timeout   <= 1'b0;
          end else if (tmo_hit) begin
            res_data      <= '0;
            res_overflow  <= 1'b0;
            res_underflow <= 1'b0;
            res_timeout   <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        DELIVER: begin
          if (res_ready) begin
            m_of_sat <= 1'b0;
            m_uf_sat <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign res_id    = grant;
  assign res_len   = beat_cnt;
  assign busy      = (state != IDLE);
  assign fsm_state = state;

endmodule

// File: tb/tb_fixed_mac_arbiter.sv
// Directed bench for fixed_mac_arbiter with a behavioural MAC stand-in and a result scoreboard.
module tb_fixed_mac_arbiter;
  import fixed_mac_arb_pkg::*;

  localparam int NREQ = 4, WA = 16, WB = 12, WO = 20, TIMEOUT = 64, LENW = 8;
  localparam int GW = 2;
  localparam int RW = GW + LENW + WO + 3;

  logic               clk, reset;
  logic [NREQ*WA-1:0] s_a_data;
  logic [NREQ-1:0]    s_a_valid, s_a_last, s_a_ready;
  logic [NREQ*WB-1:0] s_b_data;
  logic [NREQ-1:0]    s_b_valid, s_b_last, s_b_ready;
  logic [NREQ-1:0]    s_of_sat, s_uf_sat;
  logic [WA-1:0]      m_a_data;
  logic               m_a_valid, m_a_last, m_a_ready;
  logic [WB-1:0]      m_b_data;
  logic               m_b_valid, m_b_last, m_b_ready;
  logic               m_of_sat, m_uf_sat;
  logic [WO-1:0]      m_out_data;
  logic               m_out_valid, m_out_ready, m_overflow, m_underflow;
  logic [WO-1:0]      res_data;
  logic [GW-1:0]      res_id;
  logic [LENW-1:0]    res_len;
  logic               res_overflow, res_underflow, res_timeout, res_valid, res_ready, busy;
  arb_state_t         fsm_state;

  fixed_mac_arbiter #(.NREQ(NREQ), .WA(WA), .WB(WB), .WO(WO), .TIMEOUT(TIMEOUT), .LENW(LENW)) dut (
    .clk(clk), .reset(reset),
    .s_a_data(s_a_data), .s_a_valid(s_a_valid), .s_a_last(s_a_last), .s_a_ready(s_a_ready),
    .s_b_data(s_b_data), .s_b_valid(s_b_valid), .s_b_last(s_b_last), .s_b_ready(s_b_ready),
    .s_of_sat(s_of_sat), .s_uf_sat(s_uf_sat),
    .m_a_data(m_a_data), .m_a_valid(m_a_valid), .m_a_last(m_a_last), .m_a_ready(m_a_ready),
    .m_b_data(m_b_data), .m_b_valid(m_b_valid), .m_b_last(m_b_last), .m_b_ready(m_b_ready),
    .m_of_sat(m_of_sat), .m_uf_sat(m_uf_sat),
    .m_out_data(m_out_data), .m_out_valid(m_out_valid), .m_out_ready(m_out_ready),
    .m_overflow(m_overflow), .m_underflow(m_underflow),
    .res_data(res_data), .res_id(res_id), .res_len(res_len),
    .res_overflow(res_overflow), .res_underflow(res_underflow), .res_timeout(res_timeout),
    .res_valid(res_valid), .res_ready(res_ready), .busy(busy), .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exhausted");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int checks = 0, failures = 0;
  logic [RW-1:0] exp_q[$];
  logic [15:0]   exp_beats_q[$];
  int  results_seen = 0;
  int  stall_left = 0;
  bit  stalling = 0;
  logic [RW-1:0] snap;
  bit  mac_silent = 0, mac_of = 0, mac_uf = 0, b_throttle = 0;
  bit  count_wait = 0;
  int  wait_cnt = 0;
  bit  a_fin_f[NREQ];
  bit  b_fin_f[NREQ];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] pack_res(input int id, input int len, input logic [WO-1:0] d,
                                             input logic of, input logic uf, input logic tmo);
    return {GW'(id), LENW'(len), d, of, uf, tmo};
  endfunction

  task automatic expect_job(input int id, input int na, input int nb, input logic [WO-1:0] d,
                            input logic of, input logic uf, input logic tmo);
    exp_q.push_back(pack_res(id, na, d, of, uf, tmo));
    exp_beats_q.push_back({8'(na), 8'(nb)});
  endtask

  // ---------------- result monitor ----------------
  initial begin
    logic [RW-1:0] cur;
    res_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (res_valid) begin
        cur = {res_id, res_len, res_data, res_overflow, res_underflow, res_timeout};
        if (stall_left > 0) begin
          if (!stalling) begin
            snap     = cur;
            stalling = 1'b1;
          end else begin
            check("stall_res_stable", 64'(cur), 64'(snap));
          end
          check("stall_out_ready", 64'(m_out_ready), 64'd0);
          check("stall_no_grant", 64'({s_a_ready, s_b_ready}), 64'd0);
          res_ready = 1'b0;
          stall_left--;
        end else begin
          res_ready = 1'b1;
          stalling  = 1'b0;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL result_unexpected: got %0h expected none", cur);
          end else begin
            check("result", 64'(cur), 64'(exp_q.pop_front()));
          end
          results_seen++;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (count_wait && fsm_state == WAIT_RES) wait_cnt++;
    end
  end

  // ---------------- MAC stand-in: result = sum(A) + sum(B) ----------------
  initial begin
    logic ahs, bhs, ohs, al, bl, a_fin, b_fin, closed;
    logic [WA-1:0] ad;
    logic [WB-1:0] bd;
    logic [WO-1:0] a_sum, b_sum;
    logic [7:0]    a_cnt, b_cnt;
    int lat, cyc;
    a_fin = 0; b_fin = 0; closed = 0; a_sum = 0; b_sum = 0; a_cnt = 0; b_cnt = 0; lat = 0; cyc = 0;
    m_a_ready = 1'b1; m_b_ready = 1'b1; m_out_valid = 1'b0; m_out_data = '0;
    m_overflow = 1'b0; m_underflow = 1'b0;
    forever begin
      @(negedge clk);
      ahs = m_a_valid & m_a_ready; ad = m_a_data; al = m_a_last;
      bhs = m_b_valid & m_b_ready; bd = m_b_data; bl = m_b_last;
      ohs = m_out_valid & m_out_ready;
      @(posedge clk);
      #1;
      cyc++;
      if (!reset) begin
        a_fin = 0; b_fin = 0; closed = 0; a_sum = 0; b_sum = 0; a_cnt = 0; b_cnt = 0;
        m_out_valid = 1'b0;
      end else begin
        if (ahs) begin a_sum = a_sum + WO'(ad); a_cnt++; if (al) a_fin = 1; end
        if (bhs) begin b_sum = b_sum + WO'(bd); b_cnt++; if (bl) b_fin = 1; end
        if (ohs) begin
          m_out_valid = 1'b0;
          a_fin = 0; b_fin = 0; closed = 0; a_sum = 0; b_sum = 0; a_cnt = 0; b_cnt = 0;
        end else if (a_fin && b_fin && !closed) begin
          closed = 1; lat = 3;
          if (exp_beats_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL mac_beats: got %0d/%0d expected no job", a_cnt, b_cnt);
          end else begin
            check("mac_beats", 64'({a_cnt, b_cnt}), 64'(exp_beats_q.pop_front()));
          end
          if (mac_silent) begin
            a_fin = 0; b_fin = 0; closed = 0; a_sum = 0; b_sum = 0; a_cnt = 0; b_cnt = 0;
          end
        end else if (closed && !m_out_valid) begin
          if (lat > 1) lat--;
          else begin
            m_out_valid = 1'b1; m_out_data = a_sum + b_sum;
            m_overflow = mac_of; m_underflow = mac_uf;
          end
        end
      end
      m_b_ready = !(b_throttle && (cyc % 7 == 6));
    end
  end

  // ---------------- requester drivers ----------------
  task automatic bail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: wait bound expired", name);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "bound expired");
  endtask

  task automatic drive_a(input int id, input int n, input logic [WA-1:0] v, input bit hold);
    for (int k = 0; k < n; k++) begin
      int t = 0;
      s_a_data[id*WA +: WA] = v;
      s_a_last[id]  = (k == n - 1);
      s_a_valid[id] = 1'b1;
      forever begin
        @(negedge clk);
        if (s_a_ready[id]) break;
        if (++t > 3000) bail("a_ready_wait");
      end
      @(posedge clk);
      #1;
    end
    s_a_last[id]  = 1'b0;
    s_a_valid[id] = hold;
    a_fin_f[id]   = 1'b1;
  endtask

  task automatic drive_b(input int id, input int n, input logic [WB-1:0] v);
    for (int k = 0; k < n; k++) begin
      int t = 0;
      s_b_data[id*WB +: WB] = v;
      s_b_last[id]  = (k == n - 1);
      s_b_valid[id] = 1'b1;
      forever begin
        @(negedge clk);
        if (s_b_ready[id]) break;
        if (++t > 3000) bail("b_ready_wait");
      end
      @(posedge clk);
      #1;
    end
    s_b_last[id]  = 1'b0;
    s_b_valid[id] = 1'b0;
    b_fin_f[id]   = 1'b1;
  endtask

  task automatic run_job(input int id, input int na, input logic [WA-1:0] va,
                         input int nb, input logic [WB-1:0] vb);
    a_fin_f[id] = 1'b0;
    b_fin_f[id] = 1'b0;
    fork
      drive_a(id, na, va, 1'b0);
      drive_b(id, nb, vb);
    join
  endtask

  task automatic wait_results(input int n);
    int t = 0;
    while (results_seen < n) begin
      @(negedge clk);
      if (++t > 5000) bail("wait_results");
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int base, t;
    reset = 1'b0;
    s_a_data = '0; s_a_valid = '0; s_a_last = '0;
    s_b_data = '0; s_b_valid = '0; s_b_last = '0;
    s_of_sat = '0; s_uf_sat = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", 64'({busy, m_a_valid, m_a_last, m_b_valid, m_b_last, s_a_ready, s_b_ready,
                            m_out_ready, res_valid, res_overflow, res_underflow, res_timeout,
                            m_of_sat, m_uf_sat}), 64'd0);
    check("reset_res", 64'({res_data, res_id, res_len}), 64'd0);
    check("reset_state", 64'(fsm_state), 64'(IDLE));
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Single job on requester 0: 5*0x400 + 5*0x100 = 0x1900
    expect_job(0, 5, 5, 20'h01900, 1'b0, 1'b0, 1'b0);
    run_job(0, 5, 16'h0400, 5, 12'h100);
    wait_results(1);

    // Requesters 1 and 3 together: 1 first (0x30+0x6), then 3 (0x200+0x2)
    expect_job(1, 3, 3, 20'h00036, 1'b0, 1'b0, 1'b0);
    expect_job(3, 2, 2, 20'h00202, 1'b0, 1'b0, 1'b0);
    base = results_seen;
    fork
      run_job(1, 3, 16'h0010, 3, 12'h002);
      run_job(3, 2, 16'h0100, 2, 12'h001);
      begin
        t = 0;
        while (results_seen <= base) begin
          @(negedge clk);
          check("req3_blocked", 64'({s_a_ready[3], s_b_ready[3]}), 64'd0);
          if (++t > 3000) bail("job1_wait");
        end
      end
    join
    wait_results(base + 2);

    // Requester 2: A last at beat 5, B last at beat 7 with B throttled; 5*1 + 7*3 = 0x1A
    s_of_sat[2] = 1'b1;
    mac_of      = 1'b1;
    b_throttle  = 1'b1;
    a_fin_f[2]  = 1'b0;
    b_fin_f[2]  = 1'b0;
    expect_job(2, 5, 7, 20'h0001A, 1'b1, 1'b0, 1'b0);
    base = results_seen;
    fork
      drive_a(2, 5, 16'h0001, 1'b1);
      drive_b(2, 7, 12'h003);
      begin
        t = 0;
        while (!busy) begin
          @(negedge clk);
          if (++t > 100) bail("grant_wait");
        end
        s_of_sat[2] = 1'b0;
        t = 0;
        while (!a_fin_f[2]) begin
          @(negedge clk);
          if (++t > 3000) bail("a_fin_wait");
        end
        forever begin
          @(negedge clk);
          if (b_fin_f[2]) break;
          check("a_gated_after_last", 64'({m_a_valid, s_a_ready[2]}), 64'd0);
          check("stream_until_b_last", 64'(fsm_state), 64'(STREAM));
          check("of_sat_latched", 64'({m_of_sat, m_uf_sat}), 64'b10);
          if (++t > 6000) bail("b_fin_wait");
        end
      end
    join
    check("wait_res_after_b_last", 64'(fsm_state), 64'(WAIT_RES));
    s_a_valid[2] = 1'b0;
    wait_results(base + 1);
    b_throttle = 1'b0;
    mac_of     = 1'b0;

    // MAC silent: timeout result after exactly TIMEOUT cycles in WAIT_RES
    mac_silent = 1'b1;
    wait_cnt   = 0;
    count_wait = 1'b1;
    expect_job(0, 2, 2, 20'h00000, 1'b0, 1'b0, 1'b1);
    base = results_seen;
    run_job(0, 2, 16'h1234, 2, 12'h0FF);
    wait_results(base + 1);
    count_wait = 1'b0;
    check("timeout_cycles", 64'(wait_cnt), 64'(TIMEOUT));
    mac_silent = 1'b0;

    // Pointer past 0: with 0 and 1 requesting, 1 goes first; first result stalled 10 cycles
    stall_left = 10;
    expect_job(1, 2, 2, 20'h00048, 1'b0, 1'b0, 1'b0);
    expect_job(0, 3, 3, 20'h00018, 1'b0, 1'b0, 1'b0);
    base = results_seen;
    fork
      run_job(0, 3, 16'h0003, 3, 12'h005);
      run_job(1, 2, 16'h0020, 2, 12'h004);
    join
    wait_results(base + 2);

    // Reset during STREAM after the third A beat
    s_a_data[1*WA +: WA] = 16'h0007; s_a_valid[1] = 1'b1;
    s_b_data[1*WB +: WB] = 12'h001;  s_b_valid[1] = 1'b1;
    t = 0;
    base = 0;
    while (base < 3) begin
      @(negedge clk);
      if (s_a_ready[1]) base++;
      if (++t > 200) bail("abort_beats");
    end
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("abort_ctrl", 64'({busy, m_a_valid, m_a_last, m_b_valid, m_b_last, s_a_ready, s_b_ready,
                            m_out_ready, res_valid, m_of_sat, m_uf_sat}), 64'd0);
    check("abort_res", 64'({res_data, res_id, res_len, res_timeout}), 64'd0);
    check("abort_state", 64'(fsm_state), 64'(IDLE));
    s_a_valid[1] = 1'b0;
    s_b_valid[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    expect_job(2, 4, 4, 20'h0000C, 1'b0, 1'b0, 1'b0);
    base = results_seen;
    run_job(2, 4, 16'h0002, 4, 12'h001);
    wait_results(base + 1);

    repeat (5) @(posedge clk);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    check("beats_q_drained", 64'(exp_beats_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
